div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider that sits beside the execute stage.
- Execute issues DIV/DIVU operands with start_i and stalls until ready_o.
- Execute then captures {remainder, quotient} for the HI/LO write-back path.
- Performs one quotient bit per cycle and supports signed and unsigned operands.

---
 rtl/div_unit.sv | 93 +++++++++
 tb/tb_div_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider, signed and unsigned, {remainder, quotient} result
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic sn_q, sn_d, sd_q, sd_d, ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic [DATA_W:0] trial;
  logic [DATA_W-1:0] q_fix, r_fix;
  always_comb begin
    trial = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};
    q_fix = (sn_q ^ sd_q) ? -dvd_q : dvd_q;
    r_fix = sn_q ? -rem_q : rem_q;
    state_d = state_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    sn_d = sn_q;
    sd_d = sd_q;
    ready_d = 1'b0;
    result_d = '0;
    case (state_q)
      FREE: if (start_i && !annul_i) begin
        if (opdata2_i == '0) state_d = BY_ZERO;
        else begin
          state_d = ON;
          cnt_d = '0;
          rem_d = '0;
          sn_d = signed_div_i && opdata1_i[DATA_W-1];
          sd_d = signed_div_i && opdata2_i[DATA_W-1];
          dvd_d = sn_d ? -opdata1_i : opdata1_i;
          dvs_d = sd_d ? -opdata2_i : opdata2_i;
        end
      end
      BY_ZERO: state_d = annul_i ? FREE : END;
      ON: if (annul_i) state_d = FREE;
        else if (cnt_q == CW'(DATA_W)) begin
          state_d = END;
          ready_d = 1'b1;
          result_d = {r_fix, q_fix};
        end else begin
          rem_d = trial[DATA_W] ? {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]} : trial[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
          cnt_d = cnt_q + CW'(1);
        end
      default: if (annul_i || !start_i) state_d = FREE;
        else begin
          ready_d = 1'b1;
          result_d = result_q;
        end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FREE;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      sn_q <= 1'b0;
      sd_q <= 1'b0;
      ready_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      sn_q <= sn_d;
      sd_q <= sd_d;
      ready_q <= ready_d;
      result_q <= result_d;
    end
  end
  assign result_o = result_q;
  assign ready_o = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed divides checked against an arithmetic/latency model every cycle
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b1, signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic ready_o;
  int pass_n = 0, total_n = 0;
  bit armed = 1'b0;
  int m_ph = 0, m_k = 0, m_lat = 0;
  logic [63:0] m_val = '0, exp_res = '0;
  logic exp_ready = 1'b0;
  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_div(logic sg, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; exp_ready = 0; exp_res = 0;
    end else if (m_ph == 0) begin
      if (start_i && !annul_i) begin
        m_ph = 1; m_k = 0;
        m_lat = (opdata2_i == 0) ? 2 : 33;
        m_val = ref_div(signed_div_i, opdata1_i, opdata2_i);
      end
    end else if (m_ph == 1) begin
      if (annul_i) m_ph = 0;
      else begin
        m_k++;
        if (m_k == m_lat) begin
          m_ph = 2; exp_ready = 1; exp_res = m_val;
        end
      end
    end else if (annul_i || !start_i) begin
      m_ph = 0; exp_ready = 0; exp_res = 0;
    end
  end
  always @(negedge clk) if (armed) begin
    chk("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
    chk("result_o", result_o, exp_res);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic run(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] lit, input int lat);
    int n;
    signed_div_i = sg; opdata1_i = a; opdata2_i = b; start_i = 1;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1; n++;
      if (ready_o) break;
    end
    chk({nm, " latency"}, 64'(n - 1), 64'(lat));
    chk({nm, " value"}, result_o, lit);
    tick(2);
    opdata1_i = 32'hDEAD_BEEF; opdata2_i = 0;
    tick(1);
    chk({nm, " held"}, result_o, lit);
    start_i = 0;
    tick(1);
    chk({nm, " cleared"}, {63'd0, ready_o}, 64'd0);
  endtask
  initial begin
    tick(2);
    armed = 1;
    chk("reset result", result_o, 64'd0);
    rst = 0;
    tick(1);
    run("u100/7", 0, 100, 7, 64'h00000002_0000000E, 33);
    run("s-7/2", 1, 32'hFFFF_FFF9, 2, 64'hFFFFFFFF_FFFFFFFD, 33);
    run("s7/-2", 1, 7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
    run("div0", 0, 32'h1234, 0, 64'd0, 2);
    run("ubig", 0, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFFFFFE_00000001, 33);
    start_i = 1; annul_i = 1; opdata1_i = 5; opdata2_i = 1;
    tick(1);
    start_i = 0; annul_i = 0;
    tick(3);
    signed_div_i = 0; opdata1_i = 1000; opdata2_i = 3; start_i = 1;
    tick(11);
    annul_i = 1; start_i = 0;
    tick(1);
    annul_i = 0;
    tick(40);
    chk("annul no ready", {63'd0, ready_o}, 64'd0);
    run("uFFFFFFFF/1", 0, 32'hFFFF_FFFF, 1, 64'h00000000_FFFFFFFF, 33);
    run("overflow", 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
    signed_div_i = 0; opdata1_i = 50; opdata2_i = 4; start_i = 1;
    tick(21);
    rst = 1; start_i = 0;
    tick(1);
    chk("rst ready", {63'd0, ready_o}, 64'd0);
    chk("rst result", result_o, 64'd0);
    rst = 0;
    tick(1);
    run("u9/3", 0, 9, 3, 64'h00000000_00000003, 33);
    tick(2);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
